mult_seq_param: RTL and testbench

MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_sign_adj.sv | 37 +++
 rtl/mult_seq_param.sv | 131 +++++++++++++
 tb/tb_mult_seq_param.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared state encoding and width constants for the sequential
//            shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_WIDTH_DEF = 16;
    localparam int MULT_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_sign_adj.sv
`default_nettype none
// ============================================================================
// Module   : mult_sign_adj
// Purpose  : Operand magnitudes on the way in, conditional product negate on
//            the way out, for signed multiplication.
// Revision : 1.0 - initial release
// ============================================================================
module mult_sign_adj #(
    parameter int WIDTH = 16
) (
    input  logic                 sgn_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 neg,
    input  logic                 prod_neg,
    input  logic [2*WIDTH-1:0]   prod_mag,
    output logic [2*WIDTH-1:0]   prod
);

    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = sgn_mode & a[WIDTH-1];
    assign w_b_neg = sgn_mode & b[WIDTH-1];

    // The most negative value negates to itself, which is its correct
    // unsigned magnitude 2^(WIDTH-1).
    assign a_mag = w_a_neg ? -a : a;
    assign b_mag = w_b_neg ? -b : b;
    assign neg   = w_a_neg ^ w_b_neg;

    assign prod  = prod_neg ? -prod_mag : prod_mag;

endmodule
`default_nettype wire

// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_param
// Purpose  : Sequential shift-add multiplier, one multiplier bit per clock,
//            fixed WIDTH+1 edge latency. Signed support under MULT_SEQ_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 St,
    input  logic                 Sinal,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Idle,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2*WIDTH + 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH-1);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [AW-1:0]       r_acc;
    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  r_prod;
    logic                r_idle;
    logic                r_done;

    logic [WIDTH-1:0]    w_mcand_in;
    logic [WIDTH-1:0]    w_mplier_in;
    logic [WIDTH:0]      w_sum;
    logic [AW-1:0]       w_acc_next;
    logic [2*WIDTH-1:0]  w_prod_final;
    logic                w_unused;

`ifdef MULT_SEQ_SIGNED_EN
    logic r_neg;
    logic w_neg;

    mult_sign_adj #(
        .WIDTH    (WIDTH)
    ) u_sign_adj (
        .sgn_mode (Sinal),
        .a        (Multiplicando),
        .b        (Multiplicador),
        .a_mag    (w_mcand_in),
        .b_mag    (w_mplier_in),
        .neg      (w_neg),
        .prod_neg (r_neg),
        .prod_mag (w_acc_next[2*WIDTH-1:0]),
        .prod     (w_prod_final)
    );

    assign w_unused = w_acc_next[AW-1] ^ r_acc[0];
`else
    assign w_mcand_in   = Multiplicando;
    assign w_mplier_in  = Multiplicador;
    assign w_prod_final = w_acc_next[2*WIDTH-1:0];
    assign w_unused     = ^{Sinal, w_acc_next[AW-1], r_acc[0]};
`endif

    // Upper W+1 bits accumulate; the sum shifts right into the low half as
    // multiplier bits are consumed, so after WIDTH steps the product is whole.
    assign w_sum      = r_acc[AW-1:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {1'b0, w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_idle   <= 1'b1;
            r_done   <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (St) begin
                        r_mcand  <= w_mcand_in;
                        r_mplier <= w_mplier_in;
`ifdef MULT_SEQ_SIGNED_EN
                        r_neg    <= w_neg;
`endif
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_idle   <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_prod  <= w_prod_final;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_idle  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_idle  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Produto = r_prod;
    assign Idle    = r_idle;
    assign Done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_param
// Purpose  : Directed self-checking bench for mult_seq_param (WIDTH 16 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st16, sinal16, idle16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        st8, sinal8, idle8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    mult_seq_param #(.WIDTH(16)) u_dut16 (
        .Clk(clk), .Rst(rst), .St(st16), .Sinal(sinal16),
        .Multiplicando(a16), .Multiplicador(b16),
        .Produto(p16), .Idle(idle16), .Done(done16)
    );

    mult_seq_param #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Rst(rst), .St(st8), .Sinal(sinal8),
        .Multiplicando(a8), .Multiplicador(b8),
        .Produto(p8), .Idle(idle8), .Done(done8)
    );

    logic        sel8;
    logic [31:0] p_obs;
    logic        idle_obs, done_obs;
    assign p_obs    = sel8 ? {16'd0, p8} : p16;
    assign idle_obs = sel8 ? idle8 : idle16;
    assign done_obs = sel8 ? done8 : done16;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One start cycle, wait for Done with a cycle bound, check latency,
    // product, hold-during-CALC and the return to IDLE.
    task automatic run_op(input string tag, input bit w8, input logic [15:0] a,
                          input logic [15:0] b, input logic sgn,
                          input logic [31:0] exp, input bit scramble);
        int n;
        logic [31:0] prev;
        sel8 = w8;
        @(negedge clk);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; sinal8 = sgn; st8 = 1'b1;
        end else begin
            a16 = a; b16 = b; sinal16 = sgn; st16 = 1'b1;
        end
        prev = p_obs;
        @(negedge clk);
        st8 = 1'b0; st16 = 1'b0;
        chk({tag, "/busy"}, idle_obs, 1'b0);
        n = 0;
        while (!done_obs && n < 40) begin
            if (scramble) begin
                a16 = 16'($urandom); b16 = 16'($urandom); sinal16 = ~sinal16;
                a8  = 8'($urandom);  b8  = 8'($urandom);  sinal8  = ~sinal8;
            end
            @(negedge clk);
            n++;
            if (n == 3) chk({tag, "/hold"}, p_obs, prev);
        end
        chk({tag, "/lat"}, n, w8 ? 8 : 16);
        chk({tag, "/prod"}, p_obs, exp);
        chk({tag, "/excl"}, idle_obs, 1'b0);
        @(negedge clk);
        chk({tag, "/idle"}, idle_obs, 1'b1);
        chk({tag, "/done_lo"}, done_obs, 1'b0);
    endtask

    initial begin
        int cyc, t_last, pulses;
        rst = 1'b1; sel8 = 1'b0;
        st16 = 0; sinal16 = 0; a16 = '0; b16 = '0;
        st8  = 0; sinal8  = 0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        chk("rst/p16", p16, 0);
        chk("rst/idle16", idle16, 1);
        chk("rst/done16", done16, 0);
        chk("rst/p8", p8, 0);
        chk("rst/idle8", idle8, 1);
        chk("rst/done8", done8, 0);
        rst = 1'b0;

        run_op("u2000x2000", 0, 16'd2000, 16'd2000, 1'b0, 32'h003D0900, 0);
`ifdef MULT_SEQ_SIGNED_EN
        run_op("s-3x7", 0, 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 0);
        run_op("s7fffx8000", 0, 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 0);
        run_op("s-5x6_scr", 0, 16'hFFFB, 16'h0006, 1'b1, 32'hFFFFFFE2, 1);
`else
        run_op("s-3x7", 0, 16'hFFFD, 16'h0007, 1'b1, 32'h0006FFEB, 0);
        run_op("s7fffx8000", 0, 16'h7FFF, 16'h8000, 1'b1, 32'h3FFF8000, 0);
        run_op("s-5x6_scr", 0, 16'hFFFB, 16'h0006, 1'b1, 32'h0005FFE2, 1);
`endif
        run_op("smin", 0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0);
        run_op("uffff", 0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0);
        run_op("w8_255", 1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 0);

        // St held high: back-to-back operations on the 8-bit instance
        sel8 = 1'b1;
        @(negedge clk);
        a8 = 8'd13; b8 = 8'd11; sinal8 = 1'b0; st8 = 1'b1;
        cyc = 0; t_last = 0; pulses = 0;
        repeat (35) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                chk("b2b/prod", p8, 16'h008F);
                chk("b2b/excl", idle8, 1'b0);
                if (pulses > 0) chk("b2b/gap", cyc - t_last, 10);
                t_last = cyc;
                pulses++;
            end
        end
        st8 = 1'b0;
        chk("b2b/pulses", pulses, 3);
        repeat (12) @(negedge clk);

        // Reset during CALC iteration 5
        sel8 = 1'b0;
        @(negedge clk);
        a16 = 16'd2000; b16 = 16'd2000; sinal16 = 1'b0; st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort/idle", idle16, 1'b1);
        chk("abort/prod", p16, 0);
        chk("abort/done", done16, 1'b0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done16) pulses++;
        end
        chk("abort/nodone", pulses, 0);
        run_op("u12x12", 0, 16'd12, 16'd12, 1'b0, 32'd144, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
